seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 73 +++++++
 rtl/seg7_stable_filter.sv | 61 ++++++
 rtl/seg7_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment reader and the digit-to-segment
// decoder: segment bit indices, the ten digit codes, the blank code, the
// reader FSM state type and a pattern-to-digit decode function.
//
// Segment bit order (bit index -> segment):
//   0 top, 1 upper-right, 2 lower-right, 3 bottom,
//   4 lower-left, 5 upper-left, 6 middle
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_TOP = 0;
    localparam int SEG_UR  = 1;
    localparam int SEG_LR  = 2;
    localparam int SEG_BOT = 3;
    localparam int SEG_LL  = 4;
    localparam int SEG_UL  = 5;
    localparam int SEG_MID = 6;

    localparam logic [6:0] M_TOP = 7'(1 << SEG_TOP);
    localparam logic [6:0] M_UR  = 7'(1 << SEG_UR);
    localparam logic [6:0] M_LR  = 7'(1 << SEG_LR);
    localparam logic [6:0] M_BOT = 7'(1 << SEG_BOT);
    localparam logic [6:0] M_LL  = 7'(1 << SEG_LL);
    localparam logic [6:0] M_UL  = 7'(1 << SEG_UL);
    localparam logic [6:0] M_MID = 7'(1 << SEG_MID);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_D0 = M_TOP | M_UR | M_LR | M_BOT | M_LL | M_UL;
    localparam logic [6:0] SEG_D1 = M_UR | M_LR;
    localparam logic [6:0] SEG_D2 = M_TOP | M_UR | M_BOT | M_LL | M_MID;
    localparam logic [6:0] SEG_D3 = M_TOP | M_UR | M_LR | M_BOT | M_MID;
    localparam logic [6:0] SEG_D4 = M_UR | M_LR | M_UL | M_MID;
    localparam logic [6:0] SEG_D5 = M_TOP | M_LR | M_BOT | M_UL | M_MID;
    localparam logic [6:0] SEG_D6 = M_LR | M_BOT | M_LL | M_UL | M_MID;
    localparam logic [6:0] SEG_D7 = M_TOP | M_UR | M_LR;
    localparam logic [6:0] SEG_D8 = M_TOP | M_UR | M_LR | M_BOT | M_LL | M_UL | M_MID;
    localparam logic [6:0] SEG_D9 = M_TOP | M_UR | M_LR | M_UL | M_MID;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
    } seg7_result_t;

    // Legal digit -> digit value; all-dark -> blank; anything else -> err.
    function automatic seg7_result_t seg7_decode(input logic [6:0] seg);
        seg7_result_t r;
        r = '0;
        case (seg)
            SEG_D0:    r.digit = 4'd0;
            SEG_D1:    r.digit = 4'd1;
            SEG_D2:    r.digit = 4'd2;
            SEG_D3:    r.digit = 4'd3;
            SEG_D4:    r.digit = 4'd4;
            SEG_D5:    r.digit = 4'd5;
            SEG_D6:    r.digit = 4'd6;
            SEG_D7:    r.digit = 4'd7;
            SEG_D8:    r.digit = 4'd8;
            SEG_D9:    r.digit = 4'd9;
            SEG_BLANK: r.blank = 1'b1;
            default:   r.err   = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// -----------------------------------------------------------------------------
// seg7_stable_filter
// Two-flop synchronizer for the asynchronous segment lines followed by a
// saturating stability counter.
//
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (clears synchronizer and counter)
//   i_seg      raw asynchronous segment lines
//   o_pattern  synchronized segment pattern
//   o_stable   pattern has held for STABLE_CYCLES consecutive synchronized
//              cycles; its first asserted cycle is the qualify point and it
//              stays high while the pattern keeps holding
// -----------------------------------------------------------------------------
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_seg,
    output logic [6:0] o_pattern,
    output logic       o_stable
);

    localparam logic [3:0] LP_MAX = 4'(STABLE_CYCLES);

    logic [6:0] r_meta;
    logic [6:0] r_sync;
    logic [6:0] r_prev;
    logic [3:0] r_cnt;
    logic       w_same;

    assign w_same = (r_sync == r_prev);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_seg;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != LP_MAX) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // The counter reaches STABLE_CYCLES-1 on the first cycle the pattern
    // has been seen unchanged for the full window; saturation keeps the
    // level up so a pattern held during a stall can still be picked up.
    assign o_pattern = r_sync;
    assign o_stable  = w_same && (r_cnt >= (LP_MAX - 4'd1));

endmodule

// File: rtl/seg7_reader.sv
// -----------------------------------------------------------------------------
// seg7_reader
// Reads a seven-segment display: synchronizes and debounces the segment
// lines, decodes each newly stable pattern and offers it on a valid/ready
// output.
//
// Handshake: valid_o stays high with a constant result until the cycle where
// valid_o && ready_i is seen at a rising edge; that edge is the transfer.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   seg_in[6:0]  asynchronous segment lines
//   ready_i      consumer accepts the pending result
//   valid_o      result pending
//   digit_o      decoded digit (0 when blank or error)
//   blank_o      pattern was all dark
//   err_o        pattern matched no legal code
//   overrun_o    sticky: a pending result was replaced before acceptance
//   o_dbg_state  current FSM state (0 IDLE, 1 PEND)
//
// Build option: define SEG7_READER_OVERRUN_EN to let a newer stable pattern
// replace an unaccepted result (and set overrun_o). Without it the pending
// result is kept and the newer pattern is delivered after acceptance.
// -----------------------------------------------------------------------------
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [3:0] digit_o,
    output logic       blank_o,
    output logic       err_o,
    output logic       overrun_o,
    output logic       o_dbg_state
);

    rd_state_e    r_state;
    rd_state_e    w_state_nxt;
    seg7_result_t r_result;
    seg7_result_t w_decoded;
    logic [6:0]   r_last;
    logic         r_has_last;
    logic [6:0]   w_pattern;
    logic         w_stable;
    logic         w_qualify;
    logic         w_load;
`ifdef SEG7_READER_OVERRUN_EN
    logic         r_overrun;
    logic         w_set_ovr;
`endif

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_seg    (seg_in),
        .o_pattern(w_pattern),
        .o_stable (w_stable)
    );

    assign w_decoded = seg7_decode(w_pattern);

    // Only a pattern different from the last one loaded counts, so a held
    // pattern is emitted once.
    assign w_qualify = w_stable && (!r_has_last || (w_pattern != r_last));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
`ifdef SEG7_READER_OVERRUN_EN
        w_set_ovr   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_qualify) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (ready_i) begin
                    // Transfer; a same-cycle qualify reloads and stays pending.
                    if (w_qualify) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_qualify) begin
`ifdef SEG7_READER_OVERRUN_EN
                    w_load    = 1'b1;
                    w_set_ovr = 1'b1;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_last     <= '0;
            r_has_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_result   <= w_decoded;
                r_last     <= w_pattern;
                r_has_last <= 1'b1;
            end
        end
    end

`ifdef SEG7_READER_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_set_ovr) begin
            r_overrun <= 1'b1;
        end
    end
    assign overrun_o = r_overrun;
`else
    assign overrun_o = 1'b0;
`endif

    assign valid_o     = (r_state == ST_PEND);
    assign digit_o     = r_result.digit;
    assign blank_o     = r_result.blank;
    assign err_o       = r_result.err;
    assign o_dbg_state = r_state;

endmodule
